// File: rtl/dsa_mem_arbiter.sv
// Image-memory arbiter: host (ext), pixel-fetch reads (rd) and write-back (wr) share one registered port.
// Optional build macro DSA_ARB_PERF_EN adds saturating stall/grant performance counters.
module dsa_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 18,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_rvalid,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_wdata,
  output logic                  wr_gnt,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
`ifdef DSA_ARB_PERF_EN
  ,
  output logic [31:0]           perf_rd_stall,
  output logic [31:0]           perf_wr_stall,
  output logic [31:0]           perf_ext_grants
`endif
);

  localparam int unsigned WAIT_W = 8;

  logic [WAIT_W-1:0]  wait_cnt;
  logic               rd_aged_c;
  logic               issue_rd_c;
  logic               issue_ext_c;
  logic [MEM_LAT-1:0] pipe_vld;
  logic [MEM_LAT-1:0] pipe_ext;

  assign rd_aged_c   = (wait_cnt >= WAIT_W'(STARVE_LIMIT));
  assign issue_ext_c = ext_gnt && !ext_we;
  assign issue_rd_c  = issue_ext_c || rd_gnt;
  assign rdata       = mem_rdata;
  assign busy        = ext_req || rd_req || wr_req || (|pipe_vld) || mem_read_en || mem_write_en;

  // Fixed priority with an aged rd able to jump ahead of wr, never ahead of ext.
  always_comb begin
    ext_gnt = 1'b0;
    rd_gnt  = 1'b0;
    wr_gnt  = 1'b0;
    if (ext_req)                 ext_gnt = 1'b1;
    else if (rd_req && rd_aged_c) rd_gnt = 1'b1;
    else if (wr_req)             wr_gnt  = 1'b1;
    else if (rd_req)             rd_gnt  = 1'b1;
  end

  // Registered memory command; address/data hold when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      mem_read_en  <= issue_rd_c;
      mem_write_en <= (ext_gnt && ext_we) || wr_gnt;
      if (ext_gnt) begin
        mem_addr  <= ext_addr;
        mem_wdata <= ext_wdata;
      end else if (wr_gnt) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_wdata;
      end else if (rd_gnt) begin
        mem_addr  <= rd_addr;
      end
    end
  end

  // Aging counter for the fetch requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (rd_req && !rd_gnt) begin
      if (wait_cnt != '1) wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // In-flight read tracker; the final flop aligns rvalid with mem_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld   <= '0;
      pipe_ext   <= '0;
      ext_rvalid <= 1'b0;
      rd_rvalid  <= 1'b0;
    end else begin
      pipe_vld[0] <= issue_rd_c;
      pipe_ext[0] <= issue_ext_c;
      for (int i = 1; i < int'(MEM_LAT); i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_ext[i] <= pipe_ext[i-1];
      end
      ext_rvalid <= pipe_vld[MEM_LAT-1] && pipe_ext[MEM_LAT-1];
      rd_rvalid  <= pipe_vld[MEM_LAT-1] && !pipe_ext[MEM_LAT-1];
    end
  end

`ifdef DSA_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_rd_stall   <= '0;
      perf_wr_stall   <= '0;
      perf_ext_grants <= '0;
    end else begin
      if (rd_req && !rd_gnt && perf_rd_stall != '1)  perf_rd_stall   <= perf_rd_stall + 32'd1;
      if (wr_req && !wr_gnt && perf_wr_stall != '1)  perf_wr_stall   <= perf_wr_stall + 32'd1;
      if (ext_gnt && perf_ext_grants != '1)          perf_ext_grants <= perf_ext_grants + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dsa_mem_arbiter.sv
// Bench for dsa_mem_arbiter: two instances (MEM_LAT 1 and 3) share stimulus; read results go through a scoreboard.
module tb_dsa_mem_arbiter;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 8;

  typedef struct {
    bit           is_ext;
    logic [DW-1:0] data;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ext_req = 1'b0, ext_we = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] ext_addr = '0, rd_addr = '0, wr_addr = '0;
  logic [DW-1:0] ext_wdata = '0, wr_wdata = '0;

  logic ext_gnt_v [2], ext_rvalid_v [2], rd_gnt_v [2], rd_rvalid_v [2], wr_gnt_v [2];
  logic mem_read_en_v [2], mem_write_en_v [2], busy_v [2];
  logic [AW-1:0] mem_addr_v [2];
  logic [DW-1:0] mem_wdata_v [2], rdata_v [2], mem_rdata_v [2];
`ifdef DSA_ARB_PERF_EN
  logic [31:0] perf_rd_v [2], perf_wr_v [2], perf_ext_v [2];
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t sb [2][$];
  logic [DW-1:0] phys [bit [AW-1:0]];
  logic [DW-1:0] ref_wr [bit [AW-1:0]];
  logic [DW-1:0] rp_a, rp_b0, rp_b1, rp_b2;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dsa_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(g == 0 ? 1 : 3), .STARVE_LIMIT(4)) u_dut (
      .clk(clk), .rst(rst),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt_v[g]), .ext_rvalid(ext_rvalid_v[g]),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt_v[g]), .rd_rvalid(rd_rvalid_v[g]),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_wdata(wr_wdata), .wr_gnt(wr_gnt_v[g]),
      .rdata(rdata_v[g]), .mem_read_en(mem_read_en_v[g]), .mem_write_en(mem_write_en_v[g]),
      .mem_addr(mem_addr_v[g]), .mem_wdata(mem_wdata_v[g]), .mem_rdata(mem_rdata_v[g]),
      .busy(busy_v[g])
`ifdef DSA_ARB_PERF_EN
      , .perf_rd_stall(perf_rd_v[g]), .perf_wr_stall(perf_wr_v[g]), .perf_ext_grants(perf_ext_v[g])
`endif
    );
  end

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return a[7:0] ^ 8'h4A;
  endfunction

  function automatic logic [DW-1:0] phys_rd(logic [AW-1:0] a);
    return phys.exists(a) ? phys[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_wr.exists(a) ? ref_wr[a] : init_val(a);
  endfunction

  function automatic logic [33:0] outs(int g);
    return {ext_gnt_v[g], rd_gnt_v[g], wr_gnt_v[g], ext_rvalid_v[g], rd_rvalid_v[g],
            mem_read_en_v[g], mem_write_en_v[g], busy_v[g], mem_addr_v[g], mem_wdata_v[g]};
  endfunction

  // Memory model: write-first storage, read latency 1 for instance 0 and 3 for instance 1.
  always @(posedge clk) begin
    if (mem_write_en_v[0]) phys[mem_addr_v[0]] = mem_wdata_v[0];
    if (mem_read_en_v[0]) rp_a <= phys_rd(mem_addr_v[0]);
    if (mem_read_en_v[1]) rp_b0 <= phys_rd(mem_addr_v[1]);
    rp_b1 <= rp_b0;
    rp_b2 <= rp_b1;
  end
  assign mem_rdata_v[0] = rp_a;
  assign mem_rdata_v[1] = rp_b2;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push expected reads on grant, pop and compare on rvalid.
  always @(negedge clk) begin
    if (rst) begin
      sb[0].delete();
      sb[1].delete();
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (ext_rvalid_v[g] || rd_rvalid_v[g]) begin
          checks++;
          if (sb[g].size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_rvalid dut%0d cyc=%0d ext=%b rd=%b", g, cyc, ext_rvalid_v[g], rd_rvalid_v[g]);
          end else begin
            exp_t e;
            e = sb[g].pop_front();
            if (ext_rvalid_v[g] !== e.is_ext || rd_rvalid_v[g] !== !e.is_ext || rdata_v[g] !== e.data || cyc != e.due) begin
              failures++;
              $display("FAIL sb_read dut%0d got ext=%b rd=%b data=%h cyc=%0d exp ext=%b data=%h cyc=%0d",
                       g, ext_rvalid_v[g], rd_rvalid_v[g], rdata_v[g], cyc, e.is_ext, e.data, e.due);
            end
          end
        end
        if (sb[g].size() > 0 && sb[g][0].due < cyc) begin
          checks++;
          failures++;
          $display("FAIL sb_missing_rvalid dut%0d due=%0d now=%0d", g, sb[g][0].due, cyc);
          void'(sb[g].pop_front());
        end
        if ((mem_read_en_v[g] & mem_write_en_v[g]) !== 1'b0) begin
          checks++;
          failures++;
          $display("FAIL strobe_onehot dut%0d rd=%b wr=%b", g, mem_read_en_v[g], mem_write_en_v[g]);
        end
        if (ext_gnt_v[g] && !ext_we) sb[g].push_back('{1'b1, ref_rd(ext_addr), cyc + 1 + (g == 0 ? 1 : 3)});
        if (rd_gnt_v[g]) sb[g].push_back('{1'b0, ref_rd(rd_addr), cyc + 1 + (g == 0 ? 1 : 3)});
      end
      if (ext_gnt_v[0] && ext_we) ref_wr[ext_addr] = ext_wdata;
      if (wr_gnt_v[0]) ref_wr[wr_addr] = wr_wdata;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (outs(g) !== 34'd0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d got=%h exp=0", g, outs(g));
      end
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single_read();
    rd_req = 1'b1;
    rd_addr = 18'h00010;
    @(negedge clk);
    checks++;
    if ({ext_gnt_v[0], wr_gnt_v[0], rd_gnt_v[0]} !== 3'b001) begin
      failures++;
      $display("FAIL single_gnt got=%b exp=001", {ext_gnt_v[0], wr_gnt_v[0], rd_gnt_v[0]});
    end
    next_cycle();
    rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_read_en_v[0], mem_write_en_v[0], mem_addr_v[0]} !== {2'b10, 18'h00010}) begin
      failures++;
      $display("FAIL single_cmd got=%b%b/%h exp=10/00010", mem_read_en_v[0], mem_write_en_v[0], mem_addr_v[0]);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rd_rvalid_v[0] !== 1'b1 || rdata_v[0] !== 8'h5A) begin
      failures++;
      $display("FAIL single_rdata got=%b/%h exp=1/5a", rd_rvalid_v[0], rdata_v[0]);
    end
    idle(6);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (busy_v[g] !== 1'b0) begin
        failures++;
        $display("FAIL single_idle_busy dut%0d got=%b exp=0", g, busy_v[g]);
      end
    end
  endtask

  task automatic test_all_three();
    logic [2:0]    exp_gnt [4] = '{3'b100, 3'b010, 3'b001, 3'b000};
    logic [1:0]    exp_cmd [4] = '{2'b00, 2'b10, 2'b01, 2'b10};
    logic [AW-1:0] exp_adr [4] = '{18'h0, 18'h00100, 18'h00200, 18'h00300};
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 18'h00100;
    wr_req = 1'b1; wr_addr = 18'h00200; wr_wdata = 8'h11;
    rd_req = 1'b1; rd_addr = 18'h00300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({ext_gnt_v[0], wr_gnt_v[0], rd_gnt_v[0]} !== exp_gnt[i] ||
          {mem_read_en_v[0], mem_write_en_v[0]} !== exp_cmd[i] ||
          (exp_cmd[i] != 2'b00 && mem_addr_v[0] !== exp_adr[i])) begin
        failures++;
        $display("FAIL all3_step%0d got gnt=%b cmd=%b addr=%h exp gnt=%b cmd=%b addr=%h", i,
                 {ext_gnt_v[0], wr_gnt_v[0], rd_gnt_v[0]}, {mem_read_en_v[0], mem_write_en_v[0]},
                 mem_addr_v[0], exp_gnt[i], exp_cmd[i], exp_adr[i]);
      end
      next_cycle();
      if (exp_gnt[i][2]) ext_req = 1'b0;
      if (exp_gnt[i][1]) wr_req = 1'b0;
      if (exp_gnt[i][0]) rd_req = 1'b0;
    end
    idle(6);
  endtask

  task automatic test_back_to_back();
    int first = -1, last = -1, cnt = 0;
    rd_req = 1'b1;
    rd_addr = 18'h03000;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i < 8) begin
        checks++;
        if (rd_gnt_v[1] !== 1'b1) begin
          failures++;
          $display("FAIL b2b_gnt%0d got=%b exp=1", i, rd_gnt_v[1]);
        end
      end
      if (rd_rvalid_v[1] === 1'b1) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
      next_cycle();
      if (i + 1 < 8) rd_addr = 18'(32'h3000 + i + 1);
      else rd_req = 1'b0;
    end
    checks++;
    if (cnt != 8 || first != 4 || last != 11) begin
      failures++;
      $display("FAIL b2b_rvalid_train got cnt=%0d first=%0d last=%0d exp cnt=8 first=4 last=11", cnt, first, last);
    end
    idle(2);
  endtask

  task automatic test_write_read();
    bit rd_seen = 1'b0;
    wr_req = 1'b1; wr_addr = 18'h20000; wr_wdata = 8'hC3;
    @(negedge clk);
    checks++;
    if (wr_gnt_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL wrrd_wr_gnt got=%b exp=1", wr_gnt_v[0]);
    end
    next_cycle();
    wr_req = 1'b0;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 18'h20000;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j == 0) begin
        checks++;
        if (ext_gnt_v[0] !== 1'b1) begin
          failures++;
          $display("FAIL wrrd_ext_gnt got=%b exp=1", ext_gnt_v[0]);
        end
      end
      if (j == 2) begin
        checks++;
        if (ext_rvalid_v[0] !== 1'b1 || rdata_v[0] !== 8'hC3) begin
          failures++;
          $display("FAIL wrrd_lat1 got=%b/%h exp=1/c3", ext_rvalid_v[0], rdata_v[0]);
        end
      end
      if (j == 4) begin
        checks++;
        if (ext_rvalid_v[1] !== 1'b1 || rdata_v[1] !== 8'hC3) begin
          failures++;
          $display("FAIL wrrd_lat3 got=%b/%h exp=1/c3", ext_rvalid_v[1], rdata_v[1]);
        end
      end
      if (rd_rvalid_v[0] === 1'b1 || rd_rvalid_v[1] === 1'b1) rd_seen = 1'b1;
      next_cycle();
      ext_req = 1'b0;
    end
    checks++;
    if (rd_seen !== 1'b0) begin
      failures++;
      $display("FAIL wrrd_rd_rvalid got=1 exp=0");
    end
  endtask

  task automatic test_reset_midop();
    int stray = 0;
`ifdef DSA_ARB_PERF_EN
    checks++;
    if (perf_ext_v[0] !== 32'd2) begin
      failures++;
      $display("FAIL perf_ext_before_reset got=%0d exp=2", perf_ext_v[0]);
    end
`endif
    rd_req = 1'b1;
    rd_addr = 18'h04000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (rd_gnt_v[0] !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_gnt%0d got=%b exp=1", i, rd_gnt_v[0]);
      end
      next_cycle();
      rd_addr = 18'h04001;
    end
    rd_req = 1'b0;
    rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (outs(g) !== 34'd0) begin
        failures++;
        $display("FAIL rstmid_outputs dut%0d got=%h exp=0", g, outs(g));
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
`ifdef DSA_ARB_PERF_EN
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({perf_rd_v[g], perf_wr_v[g], perf_ext_v[g]} !== 96'd0) begin
        failures++;
        $display("FAIL perf_reset dut%0d got=%0d/%0d/%0d exp=0/0/0", g, perf_rd_v[g], perf_wr_v[g], perf_ext_v[g]);
      end
    end
`endif
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ext_rvalid_v[0] || rd_rvalid_v[0] || ext_rvalid_v[1] || rd_rvalid_v[1]) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL rstmid_stray_rvalid got=%0d exp=0", stray);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    int nrd = 0, nwr = 0;
    bit exp_rd;
    rd_req = 1'b1; rd_addr = 18'h02000;
    wr_req = 1'b1; wr_addr = 18'h01000; wr_wdata = 8'h00;
    for (int c = 0; c < 15; c++) begin
      exp_rd = (c % 5 == 4);
      @(negedge clk);
      checks++;
      if ({rd_gnt_v[0], wr_gnt_v[0]} !== {exp_rd, !exp_rd}) begin
        failures++;
        $display("FAIL starve_c%0d got rd=%b wr=%b exp rd=%b wr=%b", c, rd_gnt_v[0], wr_gnt_v[0], exp_rd, !exp_rd);
      end
      next_cycle();
      if (exp_rd) begin
        nrd++;
        rd_addr = 18'(32'h2000 + nrd);
      end else begin
        nwr++;
        wr_addr = 18'(32'h1000 + nwr);
        wr_wdata = 8'(nwr);
      end
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    @(negedge clk);
`ifdef DSA_ARB_PERF_EN
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (perf_rd_v[g] !== 32'd12 || perf_wr_v[g] !== 32'd3 || perf_ext_v[g] !== 32'd0) begin
        failures++;
        $display("FAIL perf_starve dut%0d got=%0d/%0d/%0d exp=12/3/0", g, perf_rd_v[g], perf_wr_v[g], perf_ext_v[g]);
      end
    end
`endif
    checks++;
    if (nrd != 3) begin
      failures++;
      $display("FAIL starve_rd_count got=%0d exp=3", nrd);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_all_three();
    test_back_to_back();
    test_write_read();
    test_reset_midop();
    test_starvation();
    idle(8);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (sb[g].size() != 0 || busy_v[g] !== 1'b0) begin
        failures++;
        $display("FAIL final_drain dut%0d pending=%0d busy=%b exp 0/0", g, sb[g].size(), busy_v[g]);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
